// File: rtl/comb_evt_pkg.sv
// rtl/comb_evt_pkg.sv - shared defaults, FSM states and record packing for the event capture stage
package comb_evt_pkg;

  localparam int WIDTH_D = 3;
  localparam int DEPTH_D = 4;
  localparam int TS_W_D  = 16;
  localparam int CNT_W_D = 8;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } cap_state_e;

  // Record layout {ts, old, new} with the new sample in the LSBs.
  function automatic logic [TS_W_D+2*WIDTH_D-1:0] pack_evt(
    input logic [TS_W_D-1:0]  ts,
    input logic [WIDTH_D-1:0] old_v,
    input logic [WIDTH_D-1:0] new_v
  );
    return {ts, old_v, new_v};
  endfunction

endpackage

// File: rtl/comb_evt_fifo.sv
// rtl/comb_evt_fifo.sv - synchronous FIFO with registered storage head and occupancy level
module comb_evt_fifo #(
  parameter int DW    = 22,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable when the indices match.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_o  = wr_ptr_q - rd_ptr_q;
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage and pointers; storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/comb_event_capture.sv
// rtl/comb_event_capture.sv - samples a combinational vector and queues time-stamped change records
module comb_event_capture
  import comb_evt_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TS_W  = TS_W_D,
  parameter int CNT_W = CNT_W_D,
  localparam int DW   = TS_W + 2 * WIDTH,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [DW-1:0]    evt_data,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_ovf
);

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [TS_W-1:0]  ts_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             rec_req;
  logic [DW-1:0]    rec_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  if (TS_W == TS_W_D && WIDTH == WIDTH_D) begin : g_pack_default
    assign rec_data = pack_evt(ts_q, prev_q, sample_in);
  end else begin : g_pack_generic
    assign rec_data = {ts_q, prev_q, sample_in};
  end

  // Arming and change detection; every enabled cycle refreshes the baseline.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    rec_req = 1'b0;
    case (state_q)
      UNARMED: begin
        if (en) begin
          prev_d  = sample_in;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!en) begin
          state_d = UNARMED;
        end else begin
          rec_req = (sample_in != prev_q);
          prev_d  = sample_in;
        end
      end
      default: state_d = UNARMED;
    endcase
  end

  // A record is lost only when the queue is full and nothing leaves it on the same edge.
  always_comb begin
    pop  = evt_valid && evt_ready;
    drop = rec_req && fifo_full && !pop;
  end

  // FSM state, baseline and free-running timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNARMED;
      prev_q  <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ts_q    <= ts_q + 1'b1;
    end
  end

  // Sticky overflow and saturating drop count; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  comb_evt_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rec_req),
    .push_data_i (rec_data),
    .pop_i       (pop),
    .head_o      (evt_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
